regfile_wb: RTL and testbench



---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_read_port.sv | 38 +++
 rtl/regfile_wb.sv | 64 ++++++
 tb/tb_regfile_wb.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and the MEM/WB write request type for the write-back register file.
package regfile_pkg;

    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NREG       = 32;
    localparam int ZERO_REG   = 31;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/regfile_read_port.sv
// One decode-stage read port: XZR handling plus optional MEM/WB forwarding.
// Forwarding is compiled in only when REGFILE_BYPASS_EN is defined.
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     arr_data,
    input  wb_req_t               wb,
    output logic [DATA_W-1:0]     data,
    output logic                  bypass
);

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        data   = arr_data;
        bypass = 1'b0;
        if (addr == REG_ADDR_W'(ZERO_REG)) begin
            data = '0;
        end else if (wb.valid && (wb.rd == addr)) begin
            data   = wb.data;
            bypass = 1'b1;
        end
    end
`else
    // Without forwarding the pending write is invisible here; decode stalls on wb_rd instead.
    logic unused_wb;
    assign unused_wb = ^{wb.valid, wb.rd, wb.data};

    always_comb begin
        data   = arr_data;
        bypass = 1'b0;
        if (addr == REG_ADDR_W'(ZERO_REG)) begin
            data = '0;
        end
    end
`endif

endmodule

// File: rtl/regfile_wb.sv
// Write-back end of the register file: MEM/WB register, 32-entry array, two read ports.
// Optional macro REGFILE_BYPASS_EN enables forwarding from MEM/WB to the read ports.
module regfile_wb #(
    parameter int DATA_W   = 64,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_regwrite,
    input  logic [4:0]        mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [4:0]        Rn,
    input  logic [4:0]        Rm,
    output logic [DATA_W-1:0] Da,
    output logic [DATA_W-1:0] Db,
    output logic              bypass_a,
    output logic              bypass_b,
    output logic              wb_valid,
    output logic [4:0]        wb_rd
);

    import regfile_pkg::wb_req_t;

    wb_req_t           wb_reg;
    logic [DATA_W-1:0] rf_reg [NREG];

    // Commit of the old request and capture of the new one share the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_reg <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            wb_reg.valid <= mem_regwrite && (mem_rd != 5'(ZERO_REG));
            wb_reg.rd    <= mem_rd;
            wb_reg.data  <= mem_data;
            if (wb_reg.valid) begin
                rf_reg[wb_reg.rd] <= wb_reg.data;
            end
        end
    end

    assign wb_valid = wb_reg.valid;
    assign wb_rd    = wb_reg.rd;

    regfile_read_port u_port_a (
        .addr     (Rn),
        .arr_data (rf_reg[Rn]),
        .wb       (wb_reg),
        .data     (Da),
        .bypass   (bypass_a)
    );

    regfile_read_port u_port_b (
        .addr     (Rm),
        .arr_data (rf_reg[Rm]),
        .wb       (wb_reg),
        .data     (Db),
        .bypass   (bypass_b)
    );

endmodule

// File: tb/tb_regfile_wb.sv
// Randomized and directed checks of regfile_wb against an array-plus-pending-write model.
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_regwrite;
    logic [4:0]  mem_rd;
    logic [63:0] mem_data;
    logic [4:0]  Rn, Rm;
    logic [63:0] Da, Db;
    logic        bypass_a, bypass_b, wb_valid;
    logic [4:0]  wb_rd;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] m_rf [32];
    logic        m_pv;
    logic [4:0]  m_prd;
    logic [63:0] m_pdata;

    logic [63:0] obs_da, obs_db;
    logic        obs_ba, obs_bb, obs_wv;
    logic [4:0]  obs_wrd;

    always #5 clk = ~clk;

    regfile_wb dut (
        .clk          (clk),
        .reset        (reset),
        .mem_regwrite (mem_regwrite),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .Rn           (Rn),
        .Rm           (Rm),
        .Da           (Da),
        .Db           (Db),
        .bypass_a     (bypass_a),
        .bypass_b     (bypass_b),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] model_read(input logic [4:0] a);
        if (a == 5'd31) return 65'd0;
`ifdef REGFILE_BYPASS_EN
        if (m_pv && m_prd == a) return {1'b1, m_pdata};
`endif
        return {1'b0, m_rf[a]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_pv = 1'b0; m_prd = '0; m_pdata = '0;
    endtask

    // One clock: drive, sample mid-cycle against the model, then advance the model on the edge.
    task automatic cycle(input logic we, input logic [4:0] rd, input logic [63:0] d,
                         input logic [4:0] rn, input logic [4:0] rm);
        logic [64:0] ea, eb;
        mem_regwrite = we; mem_rd = rd; mem_data = d; Rn = rn; Rm = rm;
        @(negedge clk);
        obs_da = Da; obs_db = Db; obs_ba = bypass_a; obs_bb = bypass_b;
        obs_wv = wb_valid; obs_wrd = wb_rd;
        ea = model_read(rn);
        eb = model_read(rm);
        $display("cyc we=%0d rd=%0d d=0x%0h Rn=%0d Rm=%0d Da=0x%0h Db=0x%0h ba=%0d bb=%0d wv=%0d wrd=%0d",
                 we, rd, d, rn, rm, Da, Db, bypass_a, bypass_b, wb_valid, wb_rd);
        chk("Da", Da, ea[63:0]);
        chk("Db", Db, eb[63:0]);
        chk("bypass_a", 64'(bypass_a), 64'(ea[64]));
        chk("bypass_b", 64'(bypass_b), 64'(eb[64]));
        chk("wb_valid", 64'(wb_valid), 64'(m_pv));
        if (m_pv) chk("wb_rd", 64'(wb_rd), 64'(m_prd));
        @(posedge clk);
        if (m_pv) m_rf[m_prd] = m_pdata;
        m_pv = we && (rd != 5'd31); m_prd = rd; m_pdata = d;
        #1;
    endtask

    initial begin
        model_clear();
        reset = 1'b1; mem_regwrite = 0; mem_rd = 0; mem_data = 0; Rn = 0; Rm = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst_Da", Da, 64'd0);
        reset = 1'b0;

        // Single write X3 = 0xDEAD
        cycle(1, 5'd3, 64'hDEAD, 5'd0, 5'd0);
        cycle(0, 5'd0, 64'h0, 5'd3, 5'd0);
`ifdef REGFILE_BYPASS_EN
        chk("sw_c1_Da", obs_da, 64'hDEAD);
        chk("sw_c1_ba", 64'(obs_ba), 64'd1);
`else
        chk("sw_c1_Da", obs_da, 64'h0);
        chk("sw_c1_ba", 64'(obs_ba), 64'd0);
`endif
        chk("sw_c1_wv", 64'(obs_wv), 64'd1);
        chk("sw_c1_wrd", 64'(obs_wrd), 64'd3);
        cycle(0, 5'd0, 64'h0, 5'd3, 5'd0);
        chk("sw_c2_Da", obs_da, 64'hDEAD);
        chk("sw_c2_ba", 64'(obs_ba), 64'd0);

        // Back-to-back X7
        cycle(1, 5'd7, 64'd1, 5'd0, 5'd0);
        cycle(1, 5'd7, 64'd2, 5'd0, 5'd0);
        cycle(0, 5'd0, 64'd0, 5'd7, 5'd7);
`ifdef REGFILE_BYPASS_EN
        chk("b2b_Da", obs_da, 64'd2);
        chk("b2b_Db", obs_db, 64'd2);
`endif
        cycle(0, 5'd0, 64'd0, 5'd7, 5'd7);
        chk("b2b_arr_Da", obs_da, 64'd2);

        // Zero register
        cycle(1, 5'd31, 64'hFFFF, 5'd31, 5'd31);
        cycle(0, 5'd0, 64'd0, 5'd31, 5'd31);
        chk("xzr_wv", 64'(obs_wv), 64'd0);
        chk("xzr_Da", obs_da, 64'd0);

        // Dual port: X1 committed, X2 pending
        cycle(1, 5'd1, 64'h11, 5'd0, 5'd0);
        cycle(1, 5'd2, 64'h22, 5'd0, 5'd0);
        cycle(0, 5'd0, 64'd0, 5'd1, 5'd2);
        chk("dp_Da", obs_da, 64'h11);

        // Asynchronous reset with X5 pending
        cycle(1, 5'd5, 64'h5555, 5'd0, 5'd0);
        #2 reset = 1'b1;
        #1;
        chk("arst_wv", 64'(wb_valid), 64'd0);
        for (int a = 0; a < 32; a++) begin
            Rn = 5'(a); Rm = 5'(31 - a);
            #0.1;
            chk("arst_Da", Da, 64'd0);
            chk("arst_Db", Db, 64'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
        cycle(0, 5'd0, 64'd0, 5'd5, 5'd3);
        chk("arst_X5", obs_da, 64'd0);

        // Randomized traffic, read addresses biased toward the pending register
        for (int n = 0; n < 400; n++) begin
            logic we;
            logic [4:0] rd, rn, rm;
            logic [63:0] d;
            we = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            d  = {$urandom, $urandom};
            rn = ($urandom_range(0, 1) == 1) ? m_prd : 5'($urandom_range(0, 31));
            rm = ($urandom_range(0, 2) == 0) ? m_prd : 5'($urandom_range(0, 31));
            cycle(we, rd, d, rn, rm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
